fifo_drain_arbiter: RTL and testbench

FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

---
 rtl/fifo_drain_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// Drains up to p_num_chans FIFO read ports into one valid/ready stream.
// Round-robin between channels, with bursts of up to p_max_burst pops per grant.
module fifo_drain_arbiter #(
    parameter int p_num_chans = 4,
    parameter int p_bit_width = 32,
    parameter int p_max_burst = 4
) (
    input  logic                                     clk,
    input  logic                                     async_rst_n,
    input  logic [p_num_chans-1:0]                   chan_en,
    input  logic [p_num_chans-1:0]                   empty,
    input  logic [p_num_chans-1:0][p_bit_width-1:0]  rdata,
    output logic [p_num_chans-1:0]                   r_en,
    output logic [p_bit_width-1:0]                   ostream_msg,
    output logic [$clog2(p_num_chans)-1:0]           ostream_chan,
    output logic                                     ostream_val,
    input  logic                                     ostream_rdy,
    output logic                                     busy
);

    localparam int              CW        = $clog2(p_num_chans);
    localparam logic [7:0]      MAX_BURST = 8'(p_max_burst);
    localparam logic [CW-1:0]   LAST_CHAN = CW'(p_num_chans - 1);
    localparam logic [CW:0]     NUM_CHANS = (CW+1)'(p_num_chans);

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    // Reset asserts immediately but releases two clock edges later.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_int_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    state_t                 state_q, state_d;
    logic [CW-1:0]          owner_q, owner_d;
    logic [7:0]             count_q, count_d;
    logic [CW-1:0]          rr_ptr_q, rr_ptr_d;

    logic [p_bit_width-1:0] msg_q, msg_d;
    logic [CW-1:0]          chan_q, chan_d;
    logic                   val_q, val_d;

    logic [p_num_chans-1:0] eligible;
    logic                   space;
    logic                   hold_hit;
    logic                   grant_vld;
    logic [CW-1:0]          grant;
    logic [CW:0]            search_sum;
    logic [CW-1:0]          search_idx;
    logic                   pop;

    assign eligible = chan_en & ~empty;
    assign space    = !val_q || ostream_rdy;

    // Owner keeps the grant while eligible; otherwise scan upward from rr_ptr.
    // The scan runs from the far end so the nearest eligible channel wins last.
    always_comb begin
        hold_hit   = (state_q == ST_HOLD) && eligible[owner_q];
        grant      = owner_q;
        grant_vld  = hold_hit;
        search_sum = '0;
        search_idx = '0;
        if (!hold_hit) begin
            grant = '0;
            for (int k = p_num_chans - 1; k >= 0; k--) begin
                search_sum = {1'b0, rr_ptr_q} + (CW+1)'(k);
                if (search_sum >= NUM_CHANS) begin
                    search_sum = search_sum - NUM_CHANS;
                end
                search_idx = search_sum[CW-1:0];
                if (eligible[search_idx]) begin
                    grant     = search_idx;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign pop = grant_vld && space && rst_int_n;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // A stalled output freezes the arbitration state entirely.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        if (space) begin
            if (pop && hold_hit) begin
                count_d = count_q + 8'd1;
                if (count_d == MAX_BURST) begin
                    state_d = ST_IDLE;
                end
            end else if (pop) begin
                owner_d  = grant;
                count_d  = 8'd1;
                rr_ptr_d = (grant == LAST_CHAN) ? '0 : grant + CW'(1);
                state_d  = (MAX_BURST == 8'd1) ? ST_IDLE : ST_HOLD;
            end else if ((state_q == ST_HOLD) && !eligible[owner_q]) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        r_en = '0;
        if (pop) begin
            r_en[grant] = 1'b1;
        end
        busy = (state_q == ST_HOLD) || val_q;
    end

    always_comb begin
        msg_d  = msg_q;
        chan_d = chan_q;
        val_d  = val_q;
        if (pop) begin
            msg_d  = rdata[grant];
            chan_d = grant;
            val_d  = 1'b1;
        end else if (ostream_rdy) begin
            val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            msg_q  <= '0;
            chan_q <= '0;
            val_q  <= 1'b0;
        end else begin
            msg_q  <= msg_d;
            chan_q <= chan_d;
            val_q  <= val_d;
        end
    end

    assign ostream_msg  = msg_q;
    assign ostream_chan = chan_q;
    assign ostream_val  = val_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter with a behavioural model of four FIFOs.
module tb_fifo_drain_arbiter;

    localparam int NC = 4;
    localparam int BW = 32;
    localparam int MB = 4;

    logic                   clk = 1'b0;
    logic                   async_rst_n;
    logic [NC-1:0]          chan_en;
    logic [NC-1:0]          empty;
    logic [NC-1:0][BW-1:0]  rdata;
    logic [NC-1:0]          r_en;
    logic [BW-1:0]          ostream_msg;
    logic [1:0]             ostream_chan;
    logic                   ostream_val;
    logic                   ostream_rdy;
    logic                   busy;

    always #5 clk = ~clk;

    fifo_drain_arbiter #(
        .p_num_chans(NC),
        .p_bit_width(BW),
        .p_max_burst(MB)
    ) dut (
        .clk          (clk),
        .async_rst_n  (async_rst_n),
        .chan_en      (chan_en),
        .empty        (empty),
        .rdata        (rdata),
        .r_en         (r_en),
        .ostream_msg  (ostream_msg),
        .ostream_chan (ostream_chan),
        .ostream_val  (ostream_val),
        .ostream_rdy  (ostream_rdy),
        .busy         (busy)
    );

    // FIFO model: word k pushed to channel c is c*256+k.
    logic [31:0] mem [NC][32];
    int wr_cnt [NC] = '{default: 0};
    int rd_cnt [NC] = '{default: 0};

    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_fifo
            assign empty[gi] = (rd_cnt[gi] == wr_cnt[gi]);
            assign rdata[gi] = mem[gi][rd_cnt[gi][4:0]];
            always @(posedge clk) begin
                if (r_en[gi]) rd_cnt[gi] <= rd_cnt[gi] + 1;
            end
        end
    endgenerate

    int cyc = 0;
    int pop_cnt = 0;
    int r0_cnt = 0;
    int beat_chan [$];
    int beat_msg [$];
    int beat_cyc [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (r_en != '0) pop_cnt = pop_cnt + 1;
        if (r_en[0]) r0_cnt = r0_cnt + 1;
        if (ostream_val && ostream_rdy) begin
            beat_chan.push_back(int'(ostream_chan));
            beat_msg.push_back(int'(ostream_msg));
            beat_cyc.push_back(cyc);
            $display("beat cyc=%0d chan=%0d msg=%08h", cyc, ostream_chan, ostream_msg);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][wr_cnt[ch][4:0]] = {22'd0, ch, 8'(k)};
            wr_cnt[ch] = wr_cnt[ch] + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        async_rst_n = 1'b0;
        tick();
        for (int i = 0; i < NC; i++) wr_cnt[i] = rd_cnt[i];
        tick();
        async_rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic step(input string tag, input logic [3:0] exp_ren, input logic exp_val,
                        input logic [1:0] exp_chan, input logic [31:0] exp_msg);
        @(negedge clk);
        check({tag, "_ren"}, 32'(r_en), 32'(exp_ren));
        check({tag, "_val"}, 32'(ostream_val), 32'(exp_val));
        if (exp_val) begin
            check({tag, "_chan"}, 32'(ostream_chan), 32'(exp_chan));
            check({tag, "_msg"}, ostream_msg, exp_msg);
        end
        tick();
    endtask

    task automatic check_order(input string tag, input int s, input int n, input int exp_ch [20]);
        int seen [NC];
        seen = '{default: 0};
        check({tag, "_count"}, 32'(beat_chan.size() - s), 32'(n));
        for (int k = 0; k < n && (s + k) < beat_chan.size(); k++) begin
            check({tag, "_chan"}, 32'(beat_chan[s+k]), 32'(exp_ch[k]));
            check({tag, "_msg"}, 32'(beat_msg[s+k]), 32'(exp_ch[k] * 256 + seen[exp_ch[k]]));
            check({tag, "_gap"}, 32'(beat_cyc[s+k] - beat_cyc[s]), 32'(k));
            seen[exp_ch[k]] = seen[exp_ch[k]] + 1;
        end
    endtask

    int exp_fair [20] = '{0,0,0,0,2,2,2,2,0,0,0,0,2,2,2,2,0,0,2,2};
    int exp_drain [20] = '{0,0,1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0};

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s;
        int p0;
        int r0;
        async_rst_n = 1'b0;
        chan_en     = 4'hF;
        ostream_rdy = 1'b1;

        // Reset values and synchronised release.
        repeat (2) tick();
        check("rst_val",  32'(ostream_val), 32'd0);
        check("rst_ren",  32'(r_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_msg",  ostream_msg, 32'd0);
        check("rst_chan", 32'(ostream_chan), 32'd0);
        push(2'd0, 1);
        async_rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("sync_hold_ren", 32'(r_en), 32'h0);
        tick();
        @(negedge clk);
        check("sync_rel_ren", 32'(r_en), 32'h1);
        tick();

        // Single channel, three words.
        do_reset();
        push(2'd1, 3);
        step("t1c0", 4'b0010, 1'b0, 2'd0, 32'h0);
        step("t1c1", 4'b0010, 1'b1, 2'd1, 32'h100);
        step("t1c2", 4'b0010, 1'b1, 2'd1, 32'h101);
        step("t1c3", 4'b0000, 1'b1, 2'd1, 32'h102);
        step("t1c4", 4'b0000, 1'b0, 2'd0, 32'h0);
        check("t1_busy", 32'(busy), 32'd0);

        // Burst fairness between ch0 and ch2.
        do_reset();
        s = beat_chan.size();
        push(2'd0, 10);
        push(2'd2, 10);
        repeat (24) tick();
        check_order("t2", s, 20, exp_fair);

        // Backpressure on ch3.
        do_reset();
        ostream_rdy = 1'b0;
        push(2'd3, 3);
        p0 = pop_cnt;
        step("t3c0", 4'b1000, 1'b0, 2'd0, 32'h0);
        for (int k = 0; k < 5; k++) step("t3stall", 4'b0000, 1'b1, 2'd3, 32'h300);
        check("t3_pops", 32'(pop_cnt - p0), 32'd1);
        ostream_rdy = 1'b1;
        step("t3r0", 4'b1000, 1'b1, 2'd3, 32'h300);
        step("t3r1", 4'b1000, 1'b1, 2'd3, 32'h301);
        step("t3r2", 4'b0000, 1'b1, 2'd3, 32'h302);
        step("t3r3", 4'b0000, 1'b0, 2'd0, 32'h0);

        // Owner drains early, handoff without a gap.
        do_reset();
        s = beat_chan.size();
        push(2'd0, 2);
        push(2'd1, 5);
        repeat (10) tick();
        check_order("t4", s, 7, exp_drain);

        // Enable mask and mid-burst disable.
        do_reset();
        chan_en = 4'b1110;
        push(2'd0, 8);
        push(2'd1, 8);
        push(2'd2, 8);
        push(2'd3, 8);
        r0 = r0_cnt;
        step("t5c0", 4'b0010, 1'b0, 2'd0, 32'h0);
        step("t5c1", 4'b0010, 1'b1, 2'd1, 32'h100);
        step("t5c2", 4'b0010, 1'b1, 2'd1, 32'h101);
        step("t5c3", 4'b0010, 1'b1, 2'd1, 32'h102);
        step("t5c4", 4'b0100, 1'b1, 2'd1, 32'h103);
        step("t5c5", 4'b0100, 1'b1, 2'd2, 32'h200);
        chan_en = 4'b1010;
        step("t5c6", 4'b1000, 1'b1, 2'd2, 32'h201);
        step("t5c7", 4'b1000, 1'b1, 2'd3, 32'h300);
        step("t5c8", 4'b1000, 1'b1, 2'd3, 32'h301);
        step("t5c9", 4'b1000, 1'b1, 2'd3, 32'h302);
        step("t5c10", 4'b0010, 1'b1, 2'd3, 32'h303);
        check("t5_r0_pops", 32'(r0_cnt - r0), 32'd0);

        // Reset mid-burst, then restart searching from channel 0.
        do_reset();
        chan_en = 4'hF;
        push(2'd2, 6);
        step("t6c0", 4'b0100, 1'b0, 2'd0, 32'h0);
        step("t6c1", 4'b0100, 1'b1, 2'd2, 32'h200);
        #2;
        async_rst_n = 1'b0;
        #1;
        check("t6_rst_val",  32'(ostream_val), 32'd0);
        check("t6_rst_ren",  32'(r_en), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_msg",  ostream_msg, 32'd0);
        push(2'd1, 2);
        push(2'd3, 2);
        tick();
        tick();
        async_rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("t6_sync_ren", 32'(r_en), 32'h0);
        tick();
        @(negedge clk);
        check("t6_first_ren", 32'(r_en), 32'b0010);
        check("t6_first_val", 32'(ostream_val), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
